// File: rtl/updown_cnt_sched.sv
// updown_cnt_sched: round-robin scheduler sharing one up/down counter between two requesters.
// Build option SATURATE_EN: counter clamps at 0 / all-ones instead of wrapping modulo 2^WIDTH.
module updown_cnt_sched #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_dir,
    input  logic [STEP_W-1:0] req0_steps,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_dir,
    input  logic [STEP_W-1:0] req1_steps,
    output logic [WIDTH-1:0]  cnt_z,
    output logic              busy,
    output logic              owner,
    output logic              done,
    output logic              done_id
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              ptr;
    logic              job_dir;
    logic [STEP_W-1:0] remaining;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              sel_dir;
    logic [STEP_W-1:0] sel_steps;
    logic [WIDTH-1:0]  cnt_step;

    // Round-robin arbitration; ptr=0 favours req0, ptr=1 favours req1.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | ~ptr);
        grant1     = req1_valid & (~req0_valid | ptr);
        req0_ready = rst_n & (state == ST_IDLE) & grant0;
        req1_ready = rst_n & (state == ST_IDLE) & grant1;
        accept     = req0_ready | req1_ready;
        sel_dir    = grant1 ? req1_dir : req0_dir;
        sel_steps  = grant1 ? req1_steps : req0_steps;
    end

    // Next counter value for one unit step.
    always_comb begin
        cnt_step = cnt_z;
`ifdef SATURATE_EN
        if (job_dir) begin
            cnt_step = (cnt_z == '1) ? cnt_z : cnt_z + WIDTH'(1);
        end else begin
            cnt_step = (cnt_z == '0) ? cnt_z : cnt_z - WIDTH'(1);
        end
`else
        if (job_dir) begin
            cnt_step = cnt_z + WIDTH'(1);
        end else begin
            cnt_step = cnt_z - WIDTH'(1);
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (sel_steps == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (remaining == STEP_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Job capture and counter datapath; busy/done are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_z     <= '0;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            job_dir   <= 1'b0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
            done <= (state_nxt == ST_DONE);
            if (accept) begin
                owner     <= grant1;
                ptr       <= ~grant1;
                job_dir   <= sel_dir;
                remaining <= sel_steps;
            end
            if (state == ST_RUN) begin
                cnt_z     <= cnt_step;
                remaining <= remaining - STEP_W'(1);
            end
        end
    end

    assign done_id = owner;

endmodule

// File: tb/tb_updown_cnt_sched.sv
// Bench for updown_cnt_sched: job vector table, hand-written corner sequences and
// randomized two-requester traffic checked every cycle against a job-level reference model.
`timescale 1ns/1ps
module tb_updown_cnt_sched;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned STEP_W = 4;
    localparam int          MODV   = 1 << WIDTH;
    localparam int          MAXV   = MODV - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              v0, d0, v1, d1;
    logic [STEP_W-1:0] s0, s1;
    logic              r0, r1;
    logic [WIDTH-1:0]  cnt;
    logic              busy, owner, done, done_id;

    updown_cnt_sched #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (v0),
        .req0_ready (r0),
        .req0_dir   (d0),
        .req0_steps (s0),
        .req1_valid (v1),
        .req1_ready (r1),
        .req1_dir   (d1),
        .req1_steps (s1),
        .cnt_z      (cnt),
        .busy       (busy),
        .owner      (owner),
        .done       (done),
        .done_id    (done_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one job record; m_phase = edges since acceptance, -1 when idle.
    int   m_phase, m_base, m_dir, m_n, m_id, m_held, m_ptr, m_owner;
    logic acc0, acc1;

    typedef struct {
        int id;
        int dir;
        int steps;
        int exp_cnt;
    } vec_t;
    vec_t tbl[10];

    function automatic int step_val(input int base, input int dir, input int k);
`ifdef SATURATE_EN
        if (dir != 0) return (base + k > MAXV) ? MAXV : base + k;
        return (base - k < 0) ? 0 : base - k;
`else
        if (dir != 0) return (base + k) % MODV;
        return (base - k + MODV * 16) % MODV;
`endif
    endfunction

    function automatic int exp_cnt();
        return (m_phase < 0) ? m_held : step_val(m_base, m_dir, m_phase);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = -1; m_base = 0; m_dir = 0; m_n = 0;
        m_id = 0; m_held = 0; m_ptr = 0; m_owner = 0;
    endtask

    // Called just after inputs are driven following a negedge; returns at the next negedge.
    task automatic tick();
        int ew0, ew1;
        #1;
        ew0 = (m_phase < 0 && v0 && (!v1 || m_ptr == 0)) ? 1 : 0;
        ew1 = (m_phase < 0 && v1 && (!v0 || m_ptr == 1)) ? 1 : 0;
        chk("req0_ready", int'(r0), ew0);
        chk("req1_ready", int'(r1), ew1);
        acc0 = v0 & r0;
        acc1 = v1 & r1;
        @(posedge clk);
        if (ew0 + ew1 != 0) begin
            m_id    = ew1;
            m_base  = m_held;
            m_dir   = int'(ew1 != 0 ? d1 : d0);
            m_n     = int'(ew1 != 0 ? s1 : s0);
            m_phase = 0;
            m_ptr   = 1 - m_id;
            m_owner = m_id;
        end else if (m_phase >= 0) begin
            m_phase++;
            if (m_phase > m_n) begin
                m_held  = step_val(m_base, m_dir, m_n);
                m_phase = -1;
            end
        end
        @(negedge clk);
        chk("cnt_z", int'(cnt), exp_cnt());
        chk("busy", int'(busy), (m_phase >= 0) ? 1 : 0);
        chk("done", int'(done), (m_phase >= 0 && m_phase == m_n) ? 1 : 0);
        chk("owner", int'(owner), m_owner);
        if (done) chk("done_id", int'(done_id), m_id);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v0 = 1'b0; d0 = 1'b0; s0 = '0;
        v1 = 1'b0; d1 = 1'b0; s1 = '0;
        repeat (2) @(negedge clk);
        model_reset();
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_owner", int'(owner), 0);
        chk("rst_done_id", int'(done_id), 0);
        v0 = 1'b1; v1 = 1'b1;
        #1;
        chk("rst_ready0", int'(r0), 0);
        chk("rst_ready1", int'(r1), 0);
        v0 = 1'b0; v1 = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic run_job(input int id, input int dir, input int steps, input int exp_final);
        int waited;
        int k;
        logic got;
        if (id == 0) begin
            v0 = 1'b1; d0 = 1'(dir); s0 = STEP_W'(steps);
        end else begin
            v1 = 1'b1; d1 = 1'(dir); s1 = STEP_W'(steps);
        end
        waited = 0;
        got = 1'b0;
        while (!got && waited < 20) begin
            tick();
            got = (id == 0) ? acc0 : acc1;
            waited++;
        end
        chk("job_accepted", int'(got), 1);
        v0 = 1'b0; v1 = 1'b0;
        if (!got) return;
        k = 0;
        while (!done && k < steps + 4) begin
            tick();
            k++;
        end
        chk("run_cycles", k, steps);
        chk("final_cnt", int'(cnt), exp_final);
        chk("job_done_id", int'(done_id), id);
        tick();
        chk("idle_after_done", int'(busy), 0);
    endtask

    initial begin
        int order[$];
        logic seen_done0;
        logic early_r1;

        // Job table run back to back from reset.
`ifdef SATURATE_EN
        tbl[0] = '{0, 1, 5, 5};   tbl[1] = '{1, 1, 0, 5};
        tbl[2] = '{1, 1, 9, 14};  tbl[3] = '{0, 1, 3, 15};
        tbl[4] = '{1, 0, 2, 13};  tbl[5] = '{0, 0, 0, 13};
        tbl[6] = '{1, 0, 11, 2};  tbl[7] = '{0, 0, 5, 0};
        tbl[8] = '{1, 1, 15, 15}; tbl[9] = '{0, 1, 15, 15};
`else
        tbl[0] = '{0, 1, 5, 5};   tbl[1] = '{1, 1, 0, 5};
        tbl[2] = '{1, 1, 9, 14};  tbl[3] = '{0, 1, 3, 1};
        tbl[4] = '{1, 0, 2, 15};  tbl[5] = '{0, 0, 0, 15};
        tbl[6] = '{1, 0, 11, 4};  tbl[7] = '{0, 0, 5, 15};
        tbl[8] = '{1, 1, 15, 14}; tbl[9] = '{0, 1, 15, 13};
`endif
        acc0 = 1'b0; acc1 = 1'b0;
        model_reset();
        do_reset();

        // Both requesters valid after reset: req0 first, req1 only after req0's done.
        v0 = 1'b1; d0 = 1'b1; s0 = STEP_W'(2);
        v1 = 1'b1; d1 = 1'b0; s1 = STEP_W'(1);
        seen_done0 = 1'b0;
        early_r1   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (acc1 && !seen_done0) early_r1 = 1'b1;
            if (acc0) begin order.push_back(0); v0 = 1'b0; end
            if (acc1) begin order.push_back(1); v1 = 1'b0; end
            if (done && !done_id) seen_done0 = 1'b1;
            if (order.size() == 2 && !busy) break;
        end
        chk("rr_jobs", order.size(), 2);
        if (order.size() == 2) begin
            chk("rr_first", order[0], 0);
            chk("rr_second", order[1], 1);
        end
        chk("rr_early_ready1", int'(early_r1), 0);
        chk("rr_final_cnt", int'(cnt), 1);

        do_reset();
        foreach (tbl[i]) run_job(tbl[i].id, tbl[i].dir, tbl[i].steps, tbl[i].exp_cnt);

        // Reset during the third step of a down-8 job.
        do_reset();
        v0 = 1'b1; d0 = 1'b0; s0 = STEP_W'(8);
        tick();
        chk("abort_accept", int'(acc0), 1);
        v0 = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        v0 = 1'b1; v1 = 1'b1;
        #1;
        model_reset();
        chk("abort_cnt", int'(cnt), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ready0", int'(r0), 0);
        chk("abort_ready1", int'(r1), 0);
        d0 = 1'b1; s0 = STEP_W'(1);
        d1 = 1'b1; s1 = STEP_W'(2);
        rst_n = 1'b1;
        tick();
        chk("post_rst_win0", int'(acc0), 1);
        chk("post_rst_lose1", int'(acc1), 0);

        // Random traffic; requesters hold their job until accepted.
        for (int c = 0; c < 400; c++) begin
            if (acc0) v0 = 1'b0;
            if (acc1) v1 = 1'b0;
            if (!v0 && $urandom_range(0, 3) == 0) begin
                v0 = 1'b1; d0 = 1'($urandom_range(0, 1)); s0 = STEP_W'($urandom_range(0, 7));
            end
            if (!v1 && $urandom_range(0, 3) == 0) begin
                v1 = 1'b1; d1 = 1'($urandom_range(0, 1)); s1 = STEP_W'($urandom_range(0, 7));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
